// File: rtl/valve_seq_exec.sv
// valve_seq_exec: clocked valve-control instruction decode/execute unit.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ins, ins_valid         instruction {op, vidx, delay, unit, flag} and its valid
//   ins_ready              high in IDLE; an instruction is accepted on ins_valid & ins_ready
//   step, resume           debug-delay step pulse, HALT release pulse
//   valve_state            registered valve outputs
//   pc_advance             one-cycle pulse when an instruction retires
//   busy, halted, err      in WAIT, in HALT, sticky illegal-instruction flag
module valve_seq_exec #(
    parameter int VIDX_W     = 4,
    parameter int NUM_VALVES = 16,
    parameter int DELAY_W    = 10,
    parameter int TICK_DIV   = 100,
    parameter int NUM_UNITS  = 6,
    localparam int INS_W     = 3 + VIDX_W + DELAY_W + 3 + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INS_W-1:0]      ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic                  step,
    input  logic                  resume,
    output logic [NUM_VALVES-1:0] valve_state,
    output logic                  pc_advance,
    output logic                  busy,
    output logic                  halted,
    output logic                  err
);
    function automatic int pow10(input int u);
        int r;
        r = 1;
        for (int i = 0; i < NUM_UNITS + 1; i++)
            if (i < u) r = r * 10;
        return r;
    endfunction

    localparam int PRE_W  = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int UCNT_W = NUM_UNITS > 1 ? $clog2(pow10(NUM_UNITS - 1)) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;

    state_t                state, state_n;
    logic [2:0]            op, unit;
    logic [VIDX_W-1:0]     vidx;
    logic [DELAY_W-1:0]    dly, rem;
    logic                  flag, acc, bad, timed, tick, done, cur_dbg;
    logic [PRE_W-1:0]      pre;
    logic [UCNT_W-1:0]     ucnt, ulim;
    logic [NUM_VALVES-1:0] sel, pulse_mask;

    assign {op, vidx, dly, unit, flag} = ins;

    always_comb begin
        acc   = ins_valid && state == IDLE;
        bad   = op > 3'd4 || 32'(vidx) >= NUM_VALVES || 32'(unit) >= NUM_UNITS;
        timed = (op == 3'd2 || op == 3'd3) && dly != '0;
        sel   = NUM_VALVES'(1) << vidx;
        tick  = pre == PRE_W'(TICK_DIV - 1);
        // Timed completion lands on the last base tick of the last unit of the last count.
        done  = state == WAIT && (cur_dbg ? step : tick && ucnt == ulim && rem == DELAY_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state == IDLE ? (acc && !bad ? (op == 3'd0 ? HALT : timed ? WAIT : IDLE) : IDLE)
                : state == WAIT ? (done ? IDLE : WAIT)
                : (resume ? IDLE : HALT);
    end

    always_comb begin
        ins_ready = state == IDLE;
        busy      = state == WAIT;
        halted    = state == HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valve_state <= '0;
            pc_advance  <= 1'b0;
            err         <= 1'b0;
            pre         <= '0;
            ucnt        <= '0;
            ulim        <= '0;
            rem         <= '0;
            cur_dbg     <= 1'b0;
            pulse_mask  <= '0;
        end else begin
            pc_advance <= 1'b0;
            if (acc) begin
                if (bad) begin
                    err        <= 1'b1;
                    pc_advance <= 1'b1;
                end else if (op == 3'd0 || op == 3'd1) begin
                    valve_state <= flag ? valve_state | sel : valve_state & ~sel;
                    pc_advance  <= op == 3'd1;
                end else if (op == 3'd4) begin
                    valve_state <= '0;
                    pc_advance  <= 1'b1;
                end else if (!timed) begin
                    pc_advance <= 1'b1;
                end else begin
                    rem         <= dly;
                    pre         <= '0;
                    ucnt        <= '0;
                    ulim        <= UCNT_W'(pow10(int'(unit)) - 1);
                    cur_dbg     <= flag;
                    pulse_mask  <= op == 3'd3 ? sel : '0;
                    valve_state <= op == 3'd3 ? valve_state | sel : valve_state;
                end
            end
            if (state == WAIT) begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) begin
                    ucnt <= ucnt == ulim ? '0 : ucnt + 1'b1;
                    if (ucnt == ulim) rem <= rem - 1'b1;
                end
                if (done) begin
                    pc_advance  <= 1'b1;
                    valve_state <= valve_state & ~pulse_mask;
                end
            end
            if (state == HALT && resume) pc_advance <= 1'b1;
        end
    end
endmodule
